// File: rtl/pb_conditioner.sv
// Pushbutton front end: synchronizes and debounces 13 note keys plus mode and
// octave buttons, picks the highest held note and turns button presses into toggles and counts.
module pb_conditioner #(
  parameter int                   DB_CNT_W = 16,
  parameter logic [DB_CNT_W-1:0]  DB_LIMIT = 16'd50000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [12:0] pb_raw,
  input  logic        mode_raw,
  input  logic        octave_raw,
  output logic [12:0] key_held,
  output logic [3:0]  note_idx,
  output logic        note_valid,
  output logic        note_strobe,
  output logic        mode_sel,
  output logic [1:0]  octave_sel
);

  localparam int NUM_IN = 15;
  localparam int MODE_BIT = 13;
  localparam int OCT_BIT = 14;
  localparam logic [DB_CNT_W-1:0] LAST_CNT = DB_LIMIT - DB_CNT_W'(1);

  logic [NUM_IN-1:0]   raw_s;
  logic [NUM_IN-1:0]   sync1_r;
  logic [NUM_IN-1:0]   sync2_r;
  logic [NUM_IN-1:0]   db_r;
  logic [DB_CNT_W-1:0] cnt_r [NUM_IN];

  logic [3:0] enc_idx_s;
  logic       enc_any_s;
  logic       strobe_next_s;
  logic       mode_prev_r;
  logic       oct_prev_r;
  logic       mode_rise_s;
  logic       oct_rise_s;
  logic [3:0] note_idx_r;
  logic       note_valid_r;
  logic       note_strobe_r;
  logic       mode_sel_r;
  logic [1:0] octave_sel_r;

  assign raw_s = {octave_raw, mode_raw, pb_raw};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_r <= {NUM_IN{1'b0}};
      sync2_r <= {NUM_IN{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
    // Accept a new level only after DB_LIMIT consecutive disagreeing samples.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        db_r[gi]  <= 1'b0;
        cnt_r[gi] <= {DB_CNT_W{1'b0}};
      end else if (sync2_r[gi] == db_r[gi]) begin
        cnt_r[gi] <= {DB_CNT_W{1'b0}};
      end else if (cnt_r[gi] == LAST_CNT) begin
        db_r[gi]  <= sync2_r[gi];
        cnt_r[gi] <= {DB_CNT_W{1'b0}};
      end else begin
        cnt_r[gi] <= cnt_r[gi] + DB_CNT_W'(1);
      end
    end
  end

  assign key_held = db_r[12:0];

  // Highest-index held key wins.
  always_comb begin
    enc_idx_s = 4'd0;
    for (int i = 0; i < 13; i++) begin
      enc_idx_s = key_held[i] ? 4'(i) : enc_idx_s;
    end
    enc_any_s = |key_held;
    strobe_next_s = enc_any_s && (!note_valid_r || (enc_idx_s != note_idx_r));
  end

  // Note selection register; index holds its last value when nothing is pressed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      note_idx_r    <= 4'd0;
      note_valid_r  <= 1'b0;
      note_strobe_r <= 1'b0;
    end else begin
      note_valid_r  <= enc_any_s;
      note_strobe_r <= strobe_next_s;
      if (enc_any_s) begin
        note_idx_r <= enc_idx_s;
      end else begin
        note_idx_r <= note_idx_r;
      end
    end
  end

  assign mode_rise_s = db_r[MODE_BIT] & ~mode_prev_r;
  assign oct_rise_s  = db_r[OCT_BIT] & ~oct_prev_r;

  // Press edges drive the mode toggle and the octave counter independently.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_prev_r  <= 1'b0;
      oct_prev_r   <= 1'b0;
      mode_sel_r   <= 1'b0;
      octave_sel_r <= 2'd0;
    end else begin
      mode_prev_r <= db_r[MODE_BIT];
      oct_prev_r  <= db_r[OCT_BIT];
      if (mode_rise_s) begin
        mode_sel_r <= ~mode_sel_r;
      end else begin
        mode_sel_r <= mode_sel_r;
      end
      if (oct_rise_s) begin
        octave_sel_r <= octave_sel_r + 2'd1;
      end else begin
        octave_sel_r <= octave_sel_r;
      end
    end
  end

  assign note_idx    = note_idx_r;
  assign note_valid  = note_valid_r;
  assign note_strobe = note_strobe_r;
  assign mode_sel    = mode_sel_r;
  assign octave_sel  = octave_sel_r;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with DB_LIMIT=4 (key acceptance 6 edges after first sample).
module tb_pb_conditioner;

  logic        clk;
  logic        n_rst;
  logic [12:0] pb_raw;
  logic        mode_raw;
  logic        octave_raw;
  logic [12:0] key_held;
  logic [3:0]  note_idx;
  logic        note_valid;
  logic        note_strobe;
  logic        mode_sel;
  logic [1:0]  octave_sel;

  int vectors;
  int miscompares;
  logic seen;

  pb_conditioner #(.DB_CNT_W(16), .DB_LIMIT(16'd4)) dut (
    .clk(clk), .n_rst(n_rst), .pb_raw(pb_raw), .mode_raw(mode_raw),
    .octave_raw(octave_raw), .key_held(key_held), .note_idx(note_idx),
    .note_valid(note_valid), .note_strobe(note_strobe), .mode_sel(mode_sel),
    .octave_sel(octave_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key"}, 32'(key_held), 32'd0);
    chk({tag, "_idx"}, 32'(note_idx), 32'd0);
    chk({tag, "_valid"}, 32'(note_valid), 32'd0);
    chk({tag, "_strobe"}, 32'(note_strobe), 32'd0);
    chk({tag, "_mode"}, 32'(mode_sel), 32'd0);
    chk({tag, "_oct"}, 32'(octave_sel), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    n_rst = 1'b0;
    pb_raw = 13'd0;
    mode_raw = 1'b0;
    octave_raw = 1'b0;
    tick(2);
    chk_all_zero("reset");
    n_rst = 1'b1;
    tick(2);

    // Single key 5
    pb_raw = 13'h0020;
    tick(5);
    chk("k5_early", 32'(key_held), 32'h0);
    tick(1);
    chk("k5_held", 32'(key_held), 32'h20);
    chk("k5_valid_lag", 32'(note_valid), 32'd0);
    tick(1);
    chk("k5_idx", 32'(note_idx), 32'd5);
    chk("k5_valid", 32'(note_valid), 32'd1);
    chk("k5_strobe", 32'(note_strobe), 32'd1);
    tick(1);
    chk("k5_strobe_once", 32'(note_strobe), 32'd0);
    pb_raw = 13'd0;
    tick(6);
    chk("k5_rel_key", 32'(key_held), 32'h0);
    tick(1);
    chk("k5_rel_valid", 32'(note_valid), 32'd0);
    chk("k5_rel_strobe", 32'(note_strobe), 32'd0);
    chk("k5_rel_idx_hold", 32'(note_idx), 32'd5);

    // Glitch of 3 cycles on key 3 is rejected
    pb_raw = 13'h0008;
    tick(3);
    pb_raw = 13'd0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | note_strobe | (|key_held);
    end
    chk("glitch_reject", 32'(seen), 32'd0);

    // Priority: 2, then 9, then 1 under 9, then release 9
    pb_raw = 13'h0004;
    tick(7);
    chk("p2_idx", 32'(note_idx), 32'd2);
    chk("p2_strobe", 32'(note_strobe), 32'd1);
    tick(1);
    pb_raw = 13'h0204;
    tick(7);
    chk("p9_idx", 32'(note_idx), 32'd9);
    chk("p9_strobe", 32'(note_strobe), 32'd1);
    tick(1);
    chk("p9_strobe_once", 32'(note_strobe), 32'd0);
    pb_raw = 13'h0206;
    tick(6);
    chk("p1_key", 32'(key_held), 32'h206);
    tick(1);
    chk("p1_no_strobe", 32'(note_strobe), 32'd0);
    chk("p1_idx", 32'(note_idx), 32'd9);
    pb_raw = 13'h0006;
    tick(6);
    chk("r9_key", 32'(key_held), 32'h006);
    tick(1);
    chk("r9_idx", 32'(note_idx), 32'd2);
    chk("r9_strobe", 32'(note_strobe), 32'd1);
    pb_raw = 13'd0;
    tick(8);
    chk("rall_valid", 32'(note_valid), 32'd0);

    // Four octave presses wrap 1,2,3,0
    for (int p = 1; p <= 4; p++) begin
      octave_raw = 1'b1;
      tick(6);
      chk("oct_before", 32'(octave_sel), 32'(p - 1) & 32'd3);
      tick(1);
      chk("oct_after", 32'(octave_sel), 32'(p) & 32'd3);
      octave_raw = 1'b0;
      tick(8);
    end

    // Mode press held 100 cycles toggles once
    mode_raw = 1'b1;
    tick(6);
    chk("mode_before", 32'(mode_sel), 32'd0);
    tick(1);
    chk("mode_toggle", 32'(mode_sel), 32'd1);
    tick(100);
    chk("mode_no_repeat", 32'(mode_sel), 32'd1);
    mode_raw = 1'b0;
    tick(8);
    chk("mode_release", 32'(mode_sel), 32'd1);

    // Reset mid-count on key 4, key still held after release
    pb_raw = 13'h0010;
    tick(4);
    n_rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick(3);
    chk_all_zero("rst_hold");
    n_rst = 1'b1;
    tick(5);
    chk("rst_k4_early", 32'(key_held), 32'h0);
    tick(1);
    chk("rst_k4_held", 32'(key_held), 32'h10);
    tick(1);
    chk("rst_k4_idx", 32'(note_idx), 32'd4);
    chk("rst_k4_strobe", 32'(note_strobe), 32'd1);
    pb_raw = 13'd0;
    tick(8);

    // Simultaneous mode and octave presses
    mode_raw = 1'b1;
    octave_raw = 1'b1;
    tick(6);
    chk("sim_mode_before", 32'(mode_sel), 32'd0);
    chk("sim_oct_before", 32'(octave_sel), 32'd0);
    tick(1);
    chk("sim_mode_after", 32'(mode_sel), 32'd1);
    chk("sim_oct_after", 32'(octave_sel), 32'd1);

    // Buttons held through reset produce fresh edges
    tick(3);
    n_rst = 1'b0;
    #1;
    chk("held_rst_mode", 32'(mode_sel), 32'd0);
    chk("held_rst_oct", 32'(octave_sel), 32'd0);
    tick(2);
    n_rst = 1'b1;
    tick(6);
    chk("held_mode_before", 32'(mode_sel), 32'd0);
    tick(1);
    chk("held_mode_after", 32'(mode_sel), 32'd1);
    chk("held_oct_after", 32'(octave_sel), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
